// File: rtl/spike_rate_monitor_pkg.sv
// Shared definitions for the spike rate monitor: FSM state encodings and default widths.
package spike_rate_monitor_pkg;

  typedef enum logic {
    SRM_IDLE  = 1'b0,
    SRM_COUNT = 1'b1
  } srm_state_t;

  localparam int SRM_N_CH  = 3;
  localparam int SRM_CNT_W = 8;
  localparam int SRM_WIN_W = 16;

endpackage

// File: rtl/spike_rate_monitor_sat_counter.sv
// Saturating event counter with a sticky overflow flag; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      value <= sat_inc(value);
      if (&value) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/spike_rate_monitor.sv
// Per-channel spike counting over a programmable window of enabled cycles, with a
// latched shadow copy and a bit-serial debug readout of the latched counts.
import spike_rate_monitor_pkg::*;

module spike_rate_monitor #(
  parameter int N_CH  = SRM_N_CH,
  parameter int CNT_W = SRM_CNT_W,
  parameter int WIN_W = SRM_WIN_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH-1:0]       spikes_in,
  input  logic [WIN_W-1:0]      window_len,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  continuous,
  output logic                  busy,
  output logic [N_CH*CNT_W-1:0] counts,
  output logic [N_CH-1:0]       overflow,
  output logic                  counts_valid,
  output logic                  data_avail,
  input  logic                  read_req,
  output logic                  serial_out,
  output logic                  serial_valid
);

  localparam int SER_W = N_CH * CNT_W;
  localparam int BIT_W = $clog2(SER_W);

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  srm_state_t state, state_nxt;

  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] win_cnt;
  logic             start_acc;
  logic             stop_cnt;
  logic             sample;
  logic             win_last;
  logic             clr_cnt;

  logic [N_CH-1:0]  inc;
  logic [CNT_W-1:0] cnt_val [N_CH];
  logic [N_CH-1:0]  ovf_val;
  logic [SER_W-1:0] latch_counts;
  logic [N_CH-1:0]  latch_ovf;

  logic [SER_W-1:0] shift_reg;
  logic [BIT_W-1:0] bit_cnt;
  logic             read_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SRM_IDLE;
    else       state <= state_nxt;
  end

  // stop outranks the window end so an aborted window never latches
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    stop_cnt  = 1'b0;
    sample    = 1'b0;
    win_last  = 1'b0;
    case (state)
      SRM_IDLE: begin
        if (start && !stop && (window_len != '0)) begin
          start_acc = 1'b1;
          state_nxt = SRM_COUNT;
        end
      end
      SRM_COUNT: begin
        if (stop) begin
          stop_cnt  = 1'b1;
          state_nxt = SRM_IDLE;
        end else if (enable) begin
          sample = 1'b1;
          if (win_cnt == win_len_q - WIN_W'(1)) begin
            win_last  = 1'b1;
            state_nxt = continuous ? SRM_COUNT : SRM_IDLE;
          end
        end
      end
      default: state_nxt = SRM_IDLE;
    endcase
  end

  assign clr_cnt = start_acc | stop_cnt | win_last;
  assign inc     = sample ? spikes_in : '0;
  assign busy    = (state == SRM_COUNT);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_cnt),
      .inc   (inc[g]),
      .value (cnt_val[g]),
      .ovf   (ovf_val[g])
    );
  end

  // Shadow load must include the spikes of the final sample cycle itself
  always_comb begin
    latch_counts = '0;
    latch_ovf    = '0;
    for (int i = 0; i < N_CH; i++) begin
      latch_counts[i*CNT_W +: CNT_W] = sat_step(cnt_val[i], inc[i]);
      latch_ovf[i] = ovf_val[i] | (inc[i] & (&cnt_val[i]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_len_q <= '0;
      win_cnt   <= '0;
    end else begin
      if (start_acc) win_len_q <= window_len;
      if (clr_cnt)     win_cnt <= '0;
      else if (sample) win_cnt <= win_cnt + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counts       <= '0;
      overflow     <= '0;
      counts_valid <= 1'b0;
    end else begin
      counts_valid <= win_last;
      if (win_last) begin
        counts   <= latch_counts;
        overflow <= latch_ovf;
      end
    end
  end

  // Serializer: a latch in the accept cycle re-arms data_avail for the new counts
  assign read_acc   = read_req & data_avail & ~serial_valid;
  assign serial_out = serial_valid & shift_reg[SER_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_avail   <= 1'b0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      serial_valid <= 1'b0;
    end else begin
      if (win_last)      data_avail <= 1'b1;
      else if (read_acc) data_avail <= 1'b0;

      if (read_acc) begin
        shift_reg    <= counts;
        bit_cnt      <= '0;
        serial_valid <= 1'b1;
      end else if (serial_valid) begin
        shift_reg <= {shift_reg[SER_W-2:0], 1'b0};
        bit_cnt   <= bit_cnt + BIT_W'(1);
        if (bit_cnt == BIT_W'(SER_W - 1)) serial_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Directed bench for spike_rate_monitor: windows, gating, saturation, continuous mode, serial dump, reset.
module tb_spike_rate_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  spikes_in;
  logic [15:0] window_len;
  logic        start;
  logic        stop;
  logic        continuous;
  logic        busy;
  logic [23:0] counts;
  logic [2:0]  overflow;
  logic        counts_valid;
  logic        data_avail;
  logic        read_req;
  logic        serial_out;
  logic        serial_valid;

  int n_checks = 0;
  int n_fail   = 0;

  spike_rate_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .spikes_in    (spikes_in),
    .window_len   (window_len),
    .start        (start),
    .stop         (stop),
    .continuous   (continuous),
    .busy         (busy),
    .counts       (counts),
    .overflow     (overflow),
    .counts_valid (counts_valid),
    .data_avail   (data_avail),
    .read_req     (read_req),
    .serial_out   (serial_out),
    .serial_valid (serial_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cv(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (counts_valid) break;
    end
  endtask

  initial begin
    int n;
    int pulses;
    int vcount;
    logic [23:0] stream;

    reset = 1'b1; enable = 1'b0; spikes_in = '0; window_len = '0;
    start = 1'b0; stop = 1'b0; continuous = 1'b0; read_req = 1'b0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_counts", counts, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cv", counts_valid, 0);
    check("rst_avail", data_avail, 0);
    check("rst_serial", {serial_valid, serial_out}, 0);
    reset = 1'b0;
    tick();

    // Basic window
    window_len = 16'd10; enable = 1'b1; spikes_in = 3'b101; start = 1'b1;
    tick();
    start = 1'b0;
    check("basic_busy", busy, 1);
    wait_cv(50, n);
    check("basic_latency", n, 10);
    check("basic_counts", counts, 24'h0A000A);
    check("basic_ovf", overflow, 0);
    check("basic_busy_drop", busy, 0);
    check("basic_avail", data_avail, 1);
    tick();
    check("basic_cv_pulse", counts_valid, 0);

    // Enable gating: enable low on the first counting cycle, then alternating
    window_len = 16'd4; spikes_in = 3'b111; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    do begin
      n++;
      enable = (n % 2 == 0);
      tick();
    end while (!counts_valid && n < 40);
    check("gate_latency", n, 8);
    check("gate_counts", counts, 24'h040404);
    enable = 1'b1;

    // Saturation
    window_len = 16'd300; spikes_in = 3'b010; start = 1'b1;
    tick();
    start = 1'b0;
    wait_cv(400, n);
    check("sat_latency", n, 300);
    check("sat_counts", counts, 24'h00FF00);
    check("sat_ovf", overflow, 3'b010);

    // Continuous windows, then stop inside the third
    window_len = 16'd5; spikes_in = 3'b001; continuous = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_cv(20, n);
    check("cont_first_latency", n, 5);
    check("cont_first_counts", counts, 24'h000005);
    check("cont_first_ovf", overflow, 0);
    wait_cv(20, n);
    check("cont_second_latency", n, 5);
    check("cont_second_counts", counts, 24'h000005);
    check("cont_busy", busy, 1);
    tick();
    stop = 1'b1; continuous = 1'b0;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (counts_valid) pulses++;
    end
    check("stop_no_pulse", pulses, 0);
    check("stop_busy_later", busy, 0);

    // Build counts {03,80,FF} and dump them serially
    window_len = 16'd255; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 255; k++) begin
      spikes_in = {k < 3, k < 128, 1'b1};
      tick();
    end
    spikes_in = '0;
    check("ser_cv", counts_valid, 1);
    check("ser_counts", counts, 24'h0380FF);
    check("ser_ovf", overflow, 0);
    check("ser_idle_out", {serial_valid, serial_out}, 0);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    check("ser_avail_clr", data_avail, 0);
    vcount = 0;
    stream = '0;
    for (int i = 0; i < 24; i++) begin
      if (serial_valid) vcount++;
      stream = {stream[22:0], serial_out};
      tick();
    end
    check("ser_valid_len", vcount, 24);
    check("ser_stream", stream, 24'h0380FF);
    check("ser_valid_end", serial_valid, 0);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    tick();
    check("ser_second_req", serial_valid, 0);

    // Reset in the middle of a serial frame
    window_len = 16'd2; spikes_in = 3'b111; start = 1'b1;
    tick();
    start = 1'b0;
    wait_cv(20, n);
    check("rs_latency", n, 2);
    check("rs_counts", counts, 24'h020202);
    read_req = 1'b1;
    tick();
    read_req = 1'b0;
    repeat (10) tick();
    check("rs_shifting", serial_valid, 1);
    reset = 1'b1;
    #1;
    check("rs_serial_valid", serial_valid, 0);
    check("rs_serial_out", serial_out, 0);
    check("rs_counts_zero", counts, 0);
    check("rs_avail", data_avail, 0);
    tick();
    reset = 1'b0;
    tick();
    window_len = 16'd0; start = 1'b1;
    tick(); tick();
    check("zero_len_busy", busy, 0);
    start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
